serial_alu_ctrl: RTL and testbench

Bit-serial ALU sequencer built on the team's gate-level primitives (AND2, OR2, EXOR2, NAND2, NOT1, HA2).
- Accepts two WIDTH-bit operands and an opcode through a start/busy/done handshake.
- Steps one bit slice per clock, LSB first, and holds the result until the next operation.
- Sits between the instruction/control logic and the gate datapath, so one full-adder slice is shared across all bit positions.

---
 rtl/serial_alu_pkg.sv | 17 +
 rtl/AND2.sv | 8 +
 rtl/EXOR2.sv | 8 +
 rtl/HA2.sv | 10 +
 rtl/NAND2.sv | 8 +
 rtl/NOT1.sv | 7 +
 rtl/OR2.sv | 8 +
 rtl/alu_bit_slice.sv | 39 +++
 rtl/serial_alu_ctrl.sv | 116 +++++++++++
 tb/tb_serial_alu_ctrl.sv | 182 ++++++++++++++++++
 10 files changed

// File: rtl/serial_alu_pkg.sv
// Shared opcodes and controller state encoding for the bit-serial ALU.
package serial_alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_ADD  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/AND2.sv
// Two-input AND gate primitive.
module AND2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

// File: rtl/EXOR2.sv
// Two-input XOR gate primitive.
module EXOR2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

// File: rtl/HA2.sv
// Half adder primitive: sum and carry of two bits.
module HA2 (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/NAND2.sv
// Two-input NAND gate primitive.
module NAND2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

// File: rtl/NOT1.sv
// Inverter primitive.
module NOT1 (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

// File: rtl/OR2.sv
// Two-input OR gate primitive.
module OR2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice built from gate primitives; shared by every bit position
// of the serial datapath.
module alu_bit_slice
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       y,
    output logic       cout
);
    logic w_and, w_or, w_xor, w_nand, w_not;
    logic w_s1, w_c1, w_sum, w_c2;

    AND2  u_and  (.a(a), .b(b), .y(w_and));
    OR2   u_or   (.a(a), .b(b), .y(w_or));
    EXOR2 u_xor  (.a(a), .b(b), .y(w_xor));
    NAND2 u_nand (.a(a), .b(b), .y(w_nand));
    NOT1  u_not  (.a(a), .y(w_not));

    // Full adder as two half adders with the carries merged.
    HA2   u_ha0  (.a(a),    .b(b),   .s(w_s1),  .c(w_c1));
    HA2   u_ha1  (.a(w_s1), .b(cin), .s(w_sum), .c(w_c2));
    OR2   u_cor  (.a(w_c1), .b(w_c2), .y(cout));

    always_comb begin
        y = 1'b0;
        case (op)
            OP_AND:  y = w_and;
            OP_OR:   y = w_or;
            OP_XOR:  y = w_xor;
            OP_NAND: y = w_nand;
            OP_NOT:  y = w_not;
            OP_ADD:  y = w_sum;
            default: y = 1'b0;
        endcase
    end
endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: captures operands on start, walks one slice per
// clock LSB first, and publishes result/carry with a one-cycle done pulse.
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_r_sh;
    logic [2:0]       r_op;
    logic             r_cy;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;

    logic             w_y;
    logic             w_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_r_next;

    alu_bit_slice u_slice (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_cy),
        .op   (r_op),
        .y    (w_y),
        .cout (w_cout)
    );

    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    // The final slice bit lands in the MSB, completing the WIDTH-bit result.
    assign w_r_next = {w_y, r_r_sh};

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = start ? ST_RUN : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_r_sh   <= '0;
            r_op     <= '0;
            r_cy     <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_a_sh <= a;
                        r_b_sh <= b;
                        r_op   <= op;
                        r_cy   <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_r_sh <= w_r_next[WIDTH-1:1];
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_op == OP_ADD) r_cy <= w_cout;
                    if (w_last) begin
                        r_result <= w_r_next;
                        r_carry  <= (r_op == OP_ADD) ? w_cout : 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign carry  = r_carry;
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed and random checks of serial_alu_ctrl against a word-level model.
module tb_serial_alu_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W:0] last_exp = '0;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry)
    );

    always #5 clk = ~clk;

    // Word-level reference: {carry, result}.
    function automatic logic [W:0] ref_alu(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        case (o)
            3'd0: return {1'b0, x & y};
            3'd1: return {1'b0, x | y};
            3'd2: return {1'b0, x ^ y};
            3'd3: return {1'b0, ~(x & y)};
            3'd4: return {1'b0, ~x};
            3'd5: return {1'b0, x} + {1'b0, y};
            default: return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; drives start for exactly one rising edge.
    task automatic start_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        step();
        start = 1'b0;
    endtask

    // Walks the RUN phase from the first busy cycle up to the done cycle.
    task automatic wait_done(input string tag, input logic [W:0] exp, input int inject_at);
        int  nb = 0;
        bit  seen = 0;
        for (int c = 0; c < 4 * W && !seen; c++) begin
            if (done) begin
                seen = 1;
            end else begin
                if (busy) nb++;
                check({tag, " held"}, {24'd0, last_exp}, {24'd0, carry, result});
                if (c == inject_at) begin
                    start = 1'b1; a = '1; b = '1; op = 3'd5;
                end
                step();
                start = 1'b0;
            end
        end
        check({tag, " done_seen"}, 33'(seen), 33'd1);
        check({tag, " busy_cycles"}, 33'(nb), 33'(W));
        check({tag, " busy_at_done"}, 33'(busy), 33'd0);
        check({tag, " res"}, {24'd0, carry, result}, {24'd0, exp});
        last_exp = exp;
    endtask

    task automatic full_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W:0] exp);
        start_op(o, x, y);
        check({tag, " busy_start"}, 33'(busy), 33'd1);
        wait_done(tag, exp, -1);
        step();
        check({tag, " done_pulse"}, 33'(done), 33'd0);
    endtask

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;
        logic [W:0]   rexp;

        rst_n = 1'b0;
        repeat (2) step();
        check("rst_busy", 33'(busy), 33'd0);
        check("rst_done", 33'(done), 33'd0);
        check("rst_res", {24'd0, carry, result}, 33'd0);
        rst_n = 1'b1;
        step();

        full_op("add_5a_3c", 3'd5, 8'h5A, 8'h3C, 9'h096);
        full_op("add_ff_01", 3'd5, 8'hFF, 8'h01, 9'h100);
        full_op("xor_a5_0f", 3'd2, 8'hA5, 8'h0F, 9'h0AA);
        full_op("nand_f0_cc", 3'd3, 8'hF0, 8'hCC, 9'h03F);
        full_op("not_81", 3'd4, 8'h81, 8'hFF, 9'h07E);
        full_op("rsv_110", 3'd6, 8'hFF, 8'hFF, 9'h000);

        // start re-pulsed on the third RUN cycle must be ignored
        start_op(3'd5, 8'h10, 8'h20);
        wait_done("ign_start", 9'h030, 2);
        step();
        check("ign_start done_pulse", 33'(done), 33'd0);
        check("ign_start no_restart", 33'(busy), 33'd0);

        // reset during RUN aborts without done
        start_op(3'd5, 8'h7F, 8'h01);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst busy", 33'(busy), 33'd0);
        check("midrst res", {24'd0, carry, result}, 33'd0);
        last_exp = '0;
        begin
            int dcount = 0;
            for (int i = 0; i < W + 3; i++) begin
                if (done) dcount++;
                step();
            end
            check("midrst no_done", 33'(dcount), 33'd0);
        end
        full_op("post_rst_and", 3'd0, 8'hF3, 8'h5C, 9'h050);

        // back-to-back: start held during DONE
        start_op(3'd5, 8'h80, 8'h80);
        wait_done("b2b_first", 9'h100, -1);
        start_op(3'd1, 8'h0F, 8'hF0);
        check("b2b busy_no_gap", 33'(busy), 33'd1);
        wait_done("b2b_or", 9'h0FF, -1);
        step();
        check("b2b done_pulse", 33'(done), 33'd0);

        // random operations, some issued back-to-back from DONE
        for (int n = 0; n < 24; n++) begin
            ro   = 3'($urandom_range(0, 7));
            ra   = W'($urandom_range(0, 255));
            rb   = W'($urandom_range(0, 255));
            rexp = ref_alu(ro, ra, rb);
            start_op(ro, ra, rb);
            check("rnd busy_start", 33'(busy), 33'd1);
            wait_done($sformatf("rnd%0d_op%0d", n, ro), rexp, -1);
            if ($urandom_range(0, 1) == 0) begin
                step();
                check("rnd done_pulse", 33'(done), 33'd0);
            end
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
